// File: rtl/sync_dr_tx.sv
// Dual-rail four-phase transmitter: takes a word, drives its two-rail codeword, then returns to spacer.
// Output updates one cycle after acceptance; in_ready is low from accept until the four-phase return completes.
module sync_dr_tx #(
   parameter int W           = 8,
   parameter     ENC         = "TP",
   parameter int SYNC_STAGES = 2,
   parameter int TIMEOUT     = 1023
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic [W-1:0]   in_data,
   input  logic           in_valid,
   output logic           in_ready,
   output logic [2*W-1:0] out,
   input  logic           ack_i,
   output logic           busy,
   output logic           timeout_err,
   output logic [15:0]    tx_count
);

   localparam logic        ENC_TP   = (ENC == "TP");
   localparam logic [15:0] TMO_LAST = 16'(TIMEOUT - 1);

   typedef enum logic [1:0] {IDLE, DATA, SPACER, ERR} state_t;

   state_t                 state;
   logic [SYNC_STAGES-1:0] ack_sync;
   logic                   ack_s;
   logic                   run;
   logic [15:0]            timer;
   logic                   timer_hit;

   function automatic logic [2*W-1:0] encode(input logic [W-1:0] d);
      logic [2*W-1:0] r;
      r = '0;
      for (int i = 0; i < W; i++) r[2*i +: 2] = d[i] ? 2'b10 : 2'b01;
      return r;
   endfunction

   assign ack_s     = ack_sync[SYNC_STAGES-1];
   assign timer_hit = (timer == TMO_LAST);

   // Requiring every sync stage clear keeps a high ack that is still in flight
   // (e.g. right after reset) from opening a one-cycle acceptance window.
   assign in_ready  = run && (state == IDLE) && (ack_sync == '0) && ENC_TP;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state       <= IDLE;
         ack_sync    <= '0;
         run         <= 1'b0;
         out         <= '0;
         timer       <= '0;
         tx_count    <= '0;
         timeout_err <= 1'b0;
         busy        <= 1'b0;
      end else begin
         ack_sync <= {ack_sync[SYNC_STAGES-2:0], ack_i};
         run      <= 1'b1;
         case (state)
            IDLE: begin
               if (in_valid && in_ready) begin
                  out   <= encode(in_data);
                  state <= DATA;
                  busy  <= 1'b1;
                  timer <= '0;
               end
            end
            DATA: begin
               if (ack_s) begin
                  out   <= '0;
                  state <= SPACER;
                  timer <= '0;
               end else if (timer_hit) begin
                  out         <= '0;
                  state       <= ERR;
                  busy        <= 1'b0;
                  timeout_err <= 1'b1;
               end else begin
                  timer <= timer + 16'd1;
               end
            end
            SPACER: begin
               if (!ack_s) begin
                  state    <= IDLE;
                  busy     <= 1'b0;
                  tx_count <= tx_count + 16'd1;
               end else if (timer_hit) begin
                  state       <= ERR;
                  busy        <= 1'b0;
                  timeout_err <= 1'b1;
               end else begin
                  timer <= timer + 16'd1;
               end
            end
            ERR: begin
               out         <= '0;
               busy        <= 1'b0;
               timeout_err <= 1'b1;
            end
            default: begin
               out   <= '0;
               state <= ERR;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_sync_dr_tx.sv
// Directed bench for sync_dr_tx with W=8, SYNC_STAGES=2, TIMEOUT=10.
module tb_sync_dr_tx;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [7:0]  in_data;
   logic        in_valid;
   logic        in_ready;
   logic [15:0] out;
   logic        ack_i;
   logic        busy;
   logic        timeout_err;
   logic [15:0] tx_count;

   int n_chk = 0;
   int n_err = 0;
   logic pair11_seen = 1'b0;
   int ready_at;

   sync_dr_tx #(.W(8), .ENC("TP"), .SYNC_STAGES(2), .TIMEOUT(10)) dut (
      .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
      .in_ready(in_ready), .out(out), .ack_i(ack_i), .busy(busy),
      .timeout_err(timeout_err), .tx_count(tx_count)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      for (int i = 0; i < 8; i++)
         if (out[2*i +: 2] === 2'b11) pair11_seen = 1'b1;
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      @(negedge clk);
   endtask

   task automatic chk16(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic chk1(input string tag, input logic obs, input logic exp);
      n_chk++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   task automatic reset_dut(input logic ack_lvl);
      rst_n    = 1'b0;
      ack_i    = ack_lvl;
      in_valid = 1'b0;
      tick(2);
      rst_n = 1'b1;
      tick(1);
   endtask

   // Downstream latch model: ack once the codeword is seen, release once spacer is seen.
   task automatic handshake(input string tag);
      int k;
      tick(1);
      ack_i = 1'b1;
      for (k = 0; k < 8; k++) begin
         tick(1);
         if (out == 16'h0000) break;
      end
      chk1({tag, "_spacer"}, (out == 16'h0000) && busy, 1'b1);
      ack_i = 1'b0;
      for (k = 0; k < 8; k++) begin
         tick(1);
         if (!busy) break;
      end
      chk1({tag, "_idle"}, busy, 1'b0);
   endtask

   initial begin
      rst_n = 1'b0; ack_i = 1'b0; in_valid = 1'b0; in_data = 8'h00;
      @(negedge clk);
      tick(2);
      chk16("rst_out", out, 16'h0000);
      chk1("rst_in_ready", in_ready, 1'b0);
      chk1("rst_busy", busy, 1'b0);
      chk1("rst_timeout_err", timeout_err, 1'b0);
      chk16("rst_tx_count", tx_count, 16'd0);
      rst_n = 1'b1;
      tick(1);
      chk1("rel_in_ready", in_ready, 1'b1);

      // Single word 0xA5, ack 3 cycles after each out change
      in_data = 8'hA5; in_valid = 1'b1;
      tick(1);
      in_valid = 1'b0;
      chk16("a5_out", out, 16'h9966);
      chk1("a5_busy", busy, 1'b1);
      chk1("a5_in_ready", in_ready, 1'b0);
      tick(3);
      ack_i = 1'b1;
      tick(2);
      chk16("a5_hold", out, 16'h9966);
      tick(1);
      chk16("a5_spacer", out, 16'h0000);
      chk1("a5_spacer_busy", busy, 1'b1);
      tick(3);
      ack_i = 1'b0;
      tick(2);
      chk16("a5_cnt_pending", tx_count, 16'd0);
      tick(1);
      chk16("a5_cnt", tx_count, 16'd1);
      chk1("a5_ready_back", in_ready, 1'b1);
      chk1("a5_busy_low", busy, 1'b0);

      // Back-to-back 0x00 then 0xFF with in_valid held
      reset_dut(1'b0);
      in_data = 8'h00; in_valid = 1'b1;
      tick(1);
      chk16("b2b_w0", out, 16'h5555);
      in_data = 8'hFF;
      handshake("b2b_w0");
      chk16("b2b_cnt1", tx_count, 16'd1);
      tick(1);
      chk16("b2b_w1", out, 16'hAAAA);
      in_valid = 1'b0;
      handshake("b2b_w1");
      chk16("b2b_cnt2", tx_count, 16'd2);
      tick(2);
      chk16("b2b_no_extra", out, 16'h0000);
      chk1("b2b_no_11", pair11_seen, 1'b0);

      // Timeout in DATA: ack never rises
      reset_dut(1'b0);
      in_data = 8'h3C; in_valid = 1'b1;
      tick(1);
      in_valid = 1'b0;
      chk16("tmo_out", out, 16'h5AA5);
      tick(9);
      chk16("tmo_still_data", out, 16'h5AA5);
      chk1("tmo_not_yet", timeout_err, 1'b0);
      tick(1);
      chk1("tmo_err", timeout_err, 1'b1);
      chk16("tmo_out_spacer", out, 16'h0000);
      chk1("tmo_in_ready", in_ready, 1'b0);
      chk1("tmo_busy", busy, 1'b0);
      in_data = 8'h11; in_valid = 1'b1;
      tick(4);
      ack_i = 1'b1;
      tick(4);
      ack_i = 1'b0;
      tick(4);
      chk1("tmo_sticky", timeout_err, 1'b1);
      chk1("tmo_ready_stuck", in_ready, 1'b0);
      chk16("tmo_out_stuck", out, 16'h0000);
      reset_dut(1'b0);
      chk1("tmo_cleared", timeout_err, 1'b0);
      chk1("tmo_ready_after_rst", in_ready, 1'b1);

      // Reset while in DATA
      in_data = 8'h5A; in_valid = 1'b1;
      tick(1);
      in_valid = 1'b0;
      chk16("rd_out", out, 16'h6699);
      rst_n = 1'b0;
      tick(1);
      chk16("rd_out_spacer", out, 16'h0000);
      chk16("rd_cnt", tx_count, 16'd0);
      chk1("rd_in_ready", in_ready, 1'b0);
      rst_n = 1'b1;
      tick(1);
      chk1("rd_idle_ready", in_ready, 1'b1);
      chk1("rd_idle_busy", busy, 1'b0);

      // ack_i high across reset release
      rst_n = 1'b0; ack_i = 1'b1; in_valid = 1'b0;
      tick(2);
      rst_n = 1'b1;
      in_data = 8'hC3; in_valid = 1'b1;
      tick(1);
      chk1("ackhi_ready_first", in_ready, 1'b0);
      tick(4);
      chk1("ackhi_ready", in_ready, 1'b0);
      chk16("ackhi_out", out, 16'h0000);
      chk1("ackhi_busy", busy, 1'b0);
      ack_i = 1'b0; in_valid = 1'b0;
      ready_at = 99;
      for (int k = 1; k <= 5; k++) begin
         tick(1);
         if (in_ready) begin
            ready_at = k;
            break;
         end
      end
      chk1("ackhi_fall_latency", ready_at <= 3, 1'b1);

      // Counter wrap after preloading 65535 completed transfers
      reset_dut(1'b0);
      force dut.tx_count = 16'hFFFF;
      #1;
      release dut.tx_count;
      chk16("wrap_preload", tx_count, 16'hFFFF);
      in_data = 8'h01; in_valid = 1'b1;
      tick(1);
      in_valid = 1'b0;
      chk16("wrap_out", out, 16'h5556);
      handshake("wrap");
      chk16("wrap_cnt", tx_count, 16'h0000);

      chk1("never_11", pair11_seen, 1'b0);
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
